// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request/response bundle between the EX-stage control path and muldiv_unit.
//   master : control path; drives start/func3/rs1/rs2/rd_in/flush, observes busy/done/result/rd_out
//   slave  : muldiv_unit; the reverse directions
interface muldiv_unit_if #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned TAG_W = 5
);
   logic             start;
   logic [2:0]       func3;
   logic [XLEN-1:0]  rs1;
   logic [XLEN-1:0]  rs2;
   logic [TAG_W-1:0] rd_in;
   logic             flush;
   logic             busy;
   logic             done;
   logic [XLEN-1:0]  result;
   logic [TAG_W-1:0] rd_out;

   modport master (
      output start, func3, rs1, rs2, rd_in, flush,
      input  busy, done, result, rd_out
   );

   modport slave (
      input  start, func3, rs1, rs2, rd_in, flush,
      output busy, done, result, rd_out
   );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M-style multiply/divide engine, generalised to XLEN bits.
// One bit per cycle: shift-add multiply and restoring divide, with single-cycle fast paths
// for divide-by-zero and signed overflow.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : muldiv_unit_if slave modport
//          start/func3/rs1/rs2/rd_in/flush in; busy/done/result/rd_out out
module muldiv_unit #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned TAG_W = 5
) (
   input logic          clk,
   input logic          rst,
   muldiv_unit_if.slave bus
);
   localparam int unsigned CntW = $clog2(XLEN) + 1;

   typedef enum logic [1:0] {StIdle, StRun, StFin, StDone} state_e;

   state_e              state_q, state_d;
   logic [2:0]          op_q, op_d;
   logic [TAG_W-1:0]    tag_q, tag_d;
   logic [TAG_W-1:0]    rd_out_q, rd_out_d;
   logic [XLEN-1:0]     opnd_q, opnd_d;     // multiplicand or divisor magnitude
   logic [2*XLEN-1:0]   acc_q, acc_d;       // {hi, lo}: product, or {remainder, quotient}
   logic                neg_q, neg_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic [XLEN-1:0]     result_q, result_d;

   logic                sgn1, sgn2, ovf, fast;
   logic [XLEN-1:0]     mag1, mag2, fast_val;
   logic [XLEN:0]       mul_sum, div_sh, div_trial;
   logic [2*XLEN-1:0]   mul_next, div_next, mul_full, init_acc;
   logic [XLEN-1:0]     div_sel, div_res, fin_val;

   // Operand decode at the start edge
   always_comb begin
      sgn1     = 1'b0;
      sgn2     = 1'b0;
      fast     = 1'b0;
      fast_val = '0;
      unique case (bus.func3)
         3'b001, 3'b100, 3'b110: begin
            sgn1 = bus.rs1[XLEN-1];
            sgn2 = bus.rs2[XLEN-1];
         end
         3'b010:  sgn1 = bus.rs1[XLEN-1];
         default: ;
      endcase
      mag1 = sgn1 ? -bus.rs1 : bus.rs1;
      mag2 = sgn2 ? -bus.rs2 : bus.rs2;
      ovf  = bus.func3[2] && !bus.func3[0] &&
             (bus.rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (bus.rs2 == '1);
      if (bus.func3[2] && (bus.rs2 == '0)) begin
         fast     = 1'b1;
         fast_val = bus.func3[1] ? bus.rs1 : '1;
      end else if (ovf) begin
         fast     = 1'b1;
         fast_val = bus.func3[1] ? '0 : bus.rs1;
      end
      // Dividend or multiplier sits in the low half and is shifted out as the loop runs
      init_acc = {{XLEN{1'b0}}, (bus.func3[2] ? mag1 : mag2)};
   end

   // One iteration of each algorithm, plus the final sign fix-up and result select
   always_comb begin
      mul_sum   = acc_q[0] ? ({1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opnd_q})
                           : {1'b0, acc_q[2*XLEN-1:XLEN]};
      mul_next  = {mul_sum, acc_q[XLEN-1:1]};

      // Partial remainder is below the divisor, so one extra bit holds the shifted value
      div_sh    = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
      div_trial = div_sh - {1'b0, opnd_q};
      if (div_trial[XLEN]) begin
         div_next = {div_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      end else begin
         div_next = {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      end

      mul_full = neg_q ? -acc_q : acc_q;
      div_sel  = op_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
      div_res  = neg_q ? -div_sel : div_sel;
      unique case (op_q)
         3'b000:                 fin_val = mul_full[XLEN-1:0];
         3'b001, 3'b010, 3'b011: fin_val = mul_full[2*XLEN-1:XLEN];
         default:                fin_val = div_res;
      endcase
   end

   // Next-state logic
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      tag_d    = tag_q;
      rd_out_d = rd_out_q;
      opnd_d   = opnd_q;
      acc_d    = acc_q;
      neg_d    = neg_q;
      cnt_d    = cnt_q;
      result_d = result_q;

      unique case (state_q)
         StIdle, StDone: begin
            state_d = StIdle;
            // flush blocks a new request; a completing DONE pulse is unaffected
            if (bus.start && !bus.flush) begin
               op_d   = bus.func3;
               tag_d  = bus.rd_in;
               opnd_d = bus.func3[2] ? mag2 : mag1;
               acc_d  = init_acc;
               neg_d  = (bus.func3[2] && bus.func3[1]) ? sgn1 : (sgn1 ^ sgn2);
               cnt_d  = '0;
               if (fast) begin
                  state_d  = StDone;
                  result_d = fast_val;
                  rd_out_d = bus.rd_in;
               end else begin
                  state_d = StRun;
               end
            end
         end
         StRun: begin
            if (bus.flush) begin
               state_d = StIdle;
            end else begin
               acc_d = op_q[2] ? div_next : mul_next;
               cnt_d = cnt_q + CntW'(1);
               if (cnt_q == CntW'(XLEN - 1)) begin
                  state_d = StFin;
               end
            end
         end
         StFin: begin
            if (bus.flush) begin
               state_d = StIdle;
            end else begin
               result_d = fin_val;
               rd_out_d = tag_q;
               state_d  = StDone;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= StIdle;
         op_q     <= '0;
         tag_q    <= '0;
         rd_out_q <= '0;
         opnd_q   <= '0;
         acc_q    <= '0;
         neg_q    <= 1'b0;
         cnt_q    <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         tag_q    <= tag_d;
         rd_out_q <= rd_out_d;
         opnd_q   <= opnd_d;
         acc_q    <= acc_d;
         neg_q    <= neg_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
      end
   end

   assign bus.busy   = (state_q == StRun) || (state_q == StFin);
   assign bus.done   = (state_q == StDone);
   assign bus.result = result_q;
   assign bus.rd_out = rd_out_q;
endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
   localparam int unsigned XLEN  = 32;
   localparam int unsigned TAG_W = 5;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   muldiv_unit_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

   muldiv_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] e;
      logic        fast;
   } vec_t;

   vec_t vecs [13];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic launch(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag);
      bus.func3 = f;
      bus.rs1   = a;
      bus.rs2   = b;
      bus.rd_in = tag;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
   endtask

   // edges counts from the start edge inclusive; stops at the first sample with done high
   task automatic wait_done(inout int edges, output int busy_cnt);
      busy_cnt = 0;
      while (!bus.done && edges < 100) begin
         if (bus.busy) busy_cnt++;
         step();
         edges++;
      end
      check("done_seen", {63'd0, bus.done}, 64'd1);
   endtask

   task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, output int edges, output int busy_cnt);
      launch(f, a, b, tag);
      edges = 1;
      wait_done(edges, busy_cnt);
   endtask

   initial begin
      int          edges;
      int          busy_cnt;
      int          done_cnt;
      logic [31:0] last_res;
      logic [4:0]  last_tag;

      total = 0;
      bad   = 0;

      vecs[0]  = '{f: 3'b011, a: 32'hFFFFFFFF, b: 32'hFFFFFFFF, e: 32'hFFFFFFFE, fast: 1'b0};
      vecs[1]  = '{f: 3'b001, a: 32'hFFFFFFFF, b: 32'hFFFFFFFF, e: 32'h00000000, fast: 1'b0};
      vecs[2]  = '{f: 3'b010, a: 32'hFFFFFFFF, b: 32'h00000002, e: 32'hFFFFFFFF, fast: 1'b0};
      vecs[3]  = '{f: 3'b100, a: 32'hFFFFFFF9, b: 32'h00000002, e: 32'hFFFFFFFD, fast: 1'b0};
      vecs[4]  = '{f: 3'b110, a: 32'hFFFFFFF9, b: 32'h00000002, e: 32'hFFFFFFFF, fast: 1'b0};
      vecs[5]  = '{f: 3'b101, a: 32'd100,      b: 32'd7,        e: 32'd14,         fast: 1'b0};
      vecs[6]  = '{f: 3'b111, a: 32'd100,      b: 32'd7,        e: 32'd2,          fast: 1'b0};
      vecs[7]  = '{f: 3'b000, a: 32'h12345678, b: 32'h00000010, e: 32'h23456780, fast: 1'b0};
      vecs[8]  = '{f: 3'b110, a: 32'd100,      b: 32'hFFFFFFF9, e: 32'd2,          fast: 1'b0};
      vecs[9]  = '{f: 3'b101, a: 32'd5,        b: 32'd0,        e: 32'hFFFFFFFF, fast: 1'b1};
      vecs[10] = '{f: 3'b110, a: 32'd5,        b: 32'd0,        e: 32'd5,          fast: 1'b1};
      vecs[11] = '{f: 3'b100, a: 32'h80000000, b: 32'hFFFFFFFF, e: 32'h80000000, fast: 1'b1};
      vecs[12] = '{f: 3'b110, a: 32'h80000000, b: 32'hFFFFFFFF, e: 32'h00000000, fast: 1'b1};

      bus.start = 1'b0;
      bus.flush = 1'b0;
      bus.func3 = 3'b000;
      bus.rs1   = '0;
      bus.rs2   = '0;
      bus.rd_in = '0;
      rst       = 1'b0;
      step();
      step();
      check("rst_busy", {63'd0, bus.busy}, 64'd0);
      check("rst_done", {63'd0, bus.done}, 64'd0);
      check("rst_result", {32'd0, bus.result}, 64'd0);
      check("rst_rd_out", {59'd0, bus.rd_out}, 64'd0);
      rst = 1'b1;
      step();

      // Basic MUL with latency and busy-length checks
      run_op(3'b000, 32'd7, 32'hFFFFFFFD, 5'd5, edges, busy_cnt);
      check("mul_edges", 64'(edges), 64'd34);
      check("mul_busy_cycles", 64'(busy_cnt), 64'd33);
      check("mul_result", {32'd0, bus.result}, 64'hFFFFFFEB);
      check("mul_rd_out", {59'd0, bus.rd_out}, 64'd5);
      check("mul_busy_in_done", {63'd0, bus.busy}, 64'd0);
      step();
      check("mul_done_one_cycle", {63'd0, bus.done}, 64'd0);

      last_res = '0;
      last_tag = '0;
      for (int i = 0; i < 13; i++) begin
         run_op(vecs[i].f, vecs[i].a, vecs[i].b, 5'(i + 1), edges, busy_cnt);
         check($sformatf("vec%0d_result", i), {32'd0, bus.result}, {32'd0, vecs[i].e});
         check($sformatf("vec%0d_rd_out", i), {59'd0, bus.rd_out}, 64'(i + 1));
         check($sformatf("vec%0d_edges", i), 64'(edges), vecs[i].fast ? 64'd1 : 64'd34);
         check($sformatf("vec%0d_busy", i), 64'(busy_cnt), vecs[i].fast ? 64'd0 : 64'd33);
         last_res = vecs[i].e;
         last_tag = 5'(i + 1);
         step();
      end

      // Flush mid-DIV: abort, no done, outputs unchanged
      launch(3'b100, 32'd1000, 32'd3, 5'd20);
      for (int i = 1; i < 10; i++) step();
      check("flush_busy_before", {63'd0, bus.busy}, 64'd1);
      bus.flush = 1'b1;
      step();
      bus.flush = 1'b0;
      check("flush_busy_after", {63'd0, bus.busy}, 64'd0);
      done_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         if (bus.done) done_cnt++;
         step();
      end
      check("flush_no_done", 64'(done_cnt), 64'd0);
      check("flush_result_kept", {32'd0, bus.result}, {32'd0, last_res});
      check("flush_rd_out_kept", {59'd0, bus.rd_out}, {59'd0, last_tag});

      // start together with flush in IDLE is ignored
      bus.func3 = 3'b101;
      bus.rs1   = 32'd9;
      bus.rs2   = 32'd0;
      bus.rd_in = 5'd30;
      bus.start = 1'b1;
      bus.flush = 1'b1;
      step();
      bus.start = 1'b0;
      bus.flush = 1'b0;
      check("idle_flush_busy", {63'd0, bus.busy}, 64'd0);
      check("idle_flush_done", {63'd0, bus.done}, 64'd0);
      step();

      // start while busy is ignored
      launch(3'b000, 32'h1000, 32'h3, 5'd7);
      edges = 1;
      for (int i = 0; i < 3; i++) begin
         step();
         edges++;
      end
      bus.func3 = 3'b101;
      bus.rs1   = 32'd5;
      bus.rs2   = 32'd0;
      bus.rd_in = 5'd9;
      bus.start = 1'b1;
      step();
      edges++;
      bus.start = 1'b0;
      wait_done(edges, busy_cnt);
      check("ignore_edges", 64'(edges), 64'd34);
      check("ignore_result", {32'd0, bus.result}, 64'h3000);
      check("ignore_rd_out", {59'd0, bus.rd_out}, 64'd7);
      step();

      // Back-to-back: second start lands in the DONE cycle
      run_op(3'b000, 32'd6, 32'd7, 5'd2, edges, busy_cnt);
      check("b2b_first_result", {32'd0, bus.result}, 64'd42);
      run_op(3'b101, 32'd100, 32'd7, 5'd3, edges, busy_cnt);
      check("b2b_second_edges", 64'(edges), 64'd34);
      check("b2b_second_result", {32'd0, bus.result}, 64'd14);
      check("b2b_second_rd_out", {59'd0, bus.rd_out}, 64'd3);
      step();

      // Asynchronous reset in the middle of a MUL
      launch(3'b000, 32'd11, 32'd13, 5'd6);
      for (int i = 1; i < 14; i++) step();
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("midrst_busy", {63'd0, bus.busy}, 64'd0);
      check("midrst_done", {63'd0, bus.done}, 64'd0);
      check("midrst_result", {32'd0, bus.result}, 64'd0);
      check("midrst_rd_out", {59'd0, bus.rd_out}, 64'd0);
      step();
      step();
      rst = 1'b1;
      done_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         if (bus.done || bus.busy) done_cnt++;
         step();
      end
      check("midrst_no_activity", 64'(done_cnt), 64'd0);
      check("midrst_result_after", {32'd0, bus.result}, 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised iterative multiply/divide engine implementing the RV32M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU), generalised to any XLEN.
- Sits in the EX stage beside the ALU. The control path holds the pipeline while busy is high and writes result to rd_out when done pulses.
- Uses a one-cycle-per-bit shift-add multiply and restoring divide, with single-cycle fast paths for divide special cases.

Parameters:
- XLEN, 32, operand and result width; must be at least 4.
- TAG_W, 5, width of the destination-register tag carried alongside the operation.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE or DONE
- func3  in  3  operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1  in  XLEN  dividend / multiplicand
- rs2  in  XLEN  divisor / multiplier
- rd_in  in  TAG_W  destination tag
- flush  in  1  synchronous abort (branch or jump taken)
- busy  out  1  operation in flight
- done  out  1  one-cycle result-valid pulse
- result  out  XLEN  registered result
- rd_out  out  TAG_W  tag of the completed operation

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; busy=0, done=0, result=0, rd_out=0; all internal registers cleared. Reset mid-operation discards the operation and produces no done.
- States: IDLE, RUN, FIN, DONE.
- IDLE or DONE with start=1 (edge E0):
  - Latch func3 and rd_in.
  - Latch operand magnitudes. Signed operands are used as absolute values for MULH/DIV/REM. For MULHSU, only rs1 is signed.
  - Latch the result sign. Products: XOR of the operand signs. Quotient: XOR of the signs. Remainder: sign of the dividend.
  - Clear the count; go to RUN.
- IDLE or DONE with start=0: IDLE.
- Divide fast paths at E0, going straight to DONE (done high in the cycle after E0):
  - rs2==0: DIV/DIVU give all ones; REM/REMU give rs1.
  - Signed overflow (DIV/REM with rs1 = 1 followed by zeros, rs2 = all ones): DIV gives rs1; REM gives 0.
- RUN: one iteration per edge.
  - Multiply: 2*XLEN-bit accumulator; add if the multiplier LSB is set, then shift.
  - Divide: restoring shift-subtract, one quotient bit per edge.
  - After XLEN iterations go to FIN.
- FIN (one edge):
  - Apply two's-complement negation if the latched sign is set.
  - Select the result: low half for MUL, high half for MULH/MULHSU/MULHU, quotient for DIV/DIVU, remainder for REM/REMU.
  - Register result and rd_out; go to DONE.
- Latency: normal ops assert done in the cycle following edge E0+XLEN+1, i.e. XLEN+2 edges after start. Fast path: 1 edge.
- busy: 1 in RUN and FIN; 0 in IDLE and DONE.
- done: 1 only in DONE. DONE lasts exactly one cycle unless start restarts from it.
  - start in DONE is accepted (back-to-back operation); done is still high that cycle, and busy rises the next cycle.
- start while busy=1: ignored; the operation in flight is unaffected.
- flush:
  - In RUN or FIN: abort to IDLE next edge; no done; result and rd_out keep their previous values.
  - In DONE: the pulse still completes; a coincident start is ignored.
  - In IDLE: start is ignored.
- result and rd_out hold their last value until the next FIN or fast-path update.
- All arithmetic is modulo 2^XLEN. Negation of the most-negative value wraps to itself.
- Internal counter width: clog2(XLEN)+1.

Test Plan (XLEN=32):
- MUL rs1=7, rs2=0xFFFFFFFD, rd_in=5 -> busy 1 for 33 cycles; done pulses one cycle, 34 edges after start; result=0xFFFFFFEB; rd_out=5.
- MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. MULH same operands -> 0x00000000. MULHSU rs1=0xFFFFFFFF, rs2=2 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- Fast paths, each with done one edge after start and busy never high:
  - DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
- Start a DIV and pulse flush at edge 10 -> busy 0 after edge 11; no done; result unchanged. A start pulsed at edge 5 of a running MUL is ignored.
- Back-to-back: new start in the DONE cycle -> second done exactly 34 edges later. Separately, rst low at edge 15 of a MUL -> all outputs 0 immediately; no done after release.
